// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encodings and default latency for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_MTHI  = 3'b011,
    MDU_MTLO  = 3'b100
  } mdu_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;
  localparam int MUL_LAT_DEF = 4;
endpackage

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequences the multicycle multiplier and owns the architectural HI/LO registers
module mul_hilo_ctrl import mdu_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int W = 32
) (
  input  logic         clk_sig,
  input  logic         rst_n_sig,
  input  logic         flush_sig,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out,
  output logic         busy,
  output logic         done,
  output logic         mul_ena,
  output logic         mul_sign,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_hi,
  input  logic [W-1:0] mul_lo
);
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
  mdu_state_e state;
  mdu_op_e op;
  logic [3:0] cnt;
  logic hs;
  logic is_mul;
  assign op = mdu_op_e'(req_op);
  assign req_ready = ~busy;
  assign hs = req_valid & req_ready;
  assign is_mul = op == MDU_MULT || op == MDU_MULTU;
  // FSM: flush beats everything; IDLE/DONE accept commands, CALC holds operands until the product is sampled
  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_sign <= 1'b0;
      mul_ena  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (flush_sig) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mul_ena <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (state == S_CALC) begin
      if (cnt == '0) begin
        {hi_out, lo_out} <= {mul_hi, mul_lo};
        state   <= S_DONE;
        mul_ena <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      state <= S_IDLE;
      done  <= 1'b0;
      if (hs && is_mul) begin
        mul_a    <= op_a;
        mul_b    <= op_b;
        mul_sign <= op == MDU_MULT;
        cnt      <= CNT_INIT;
        state    <= S_CALC;
        mul_ena  <= 1'b1;
        busy     <= 1'b1;
      end
      if (hs && op == MDU_MTHI) hi_out <= op_a;
      if (hs && op == MDU_MTLO) lo_out <= op_a;
    end
  end
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb_mul_hilo_ctrl: directed scoreboard bench for the HI/LO multiply sequencer with a behavioural multiplier
module tb_mul_hilo_ctrl;
  logic clk_sig = 1'b0;
  logic rst_n_sig = 1'b0;
  logic flush_sig = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] req_op = 3'b000;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] hi_out, lo_out, mul_a, mul_b, mul_hi, mul_lo;
  logic busy, done, mul_ena, mul_sign;
  logic [63:0] prod;
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fails = 0;
  int n_done = 0;
  int n_cyc;
  int done_before;

  always #5 clk_sig = ~clk_sig;

  mul_hilo_ctrl #(.MUL_LAT(4), .W(32)) dut (
    .clk_sig(clk_sig), .rst_n_sig(rst_n_sig), .flush_sig(flush_sig),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .op_a(op_a), .op_b(op_b), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .mul_ena(mul_ena), .mul_sign(mul_sign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  always_comb begin
    prod = mul_sign ? 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}))
                    : {32'd0, mul_a} * {32'd0, mul_b};
  end
  assign {mul_hi, mul_lo} = prod;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_sig);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    int n;
    req_valid = 1'b1;
    req_op = op;
    op_a = a;
    op_b = b;
    n = 0;
    do begin
      ok = req_ready;
      step();
      n++;
    end while (!ok && n < 20);
    check("issue_accepted", 64'(ok), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("done_within_bound", 64'(done), 64'd1);
  endtask

  always @(posedge clk_sig) begin
    #1;
    if (done && rst_n_sig) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("scoreboard_hilo", {hi_out, lo_out}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_ctrl", {60'd0, busy, done, mul_ena, mul_sign}, 64'd0);
    check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    rst_n_sig = 1'b1;
    step();
    check("rst_ready", 64'(req_ready), 64'd1);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    issue(3'b001, 32'hFFFFFFFD, 32'h00000005);
    check("t1_calc_ctrl", {60'd0, busy, done, mul_ena, mul_sign}, {60'd0, 4'b1011});
    check("t1_ready_low", 64'(req_ready), 64'd0);
    n_cyc = 0;
    while (busy && n_cyc < 20) begin
      n_cyc++;
      step();
    end
    check("t1_busy_cycles", 64'(n_cyc), 64'd4);
    check("t1_done_pulse", 64'(done), 64'd1);
    check("t1_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF1);
    step();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_ena_off", 64'(mul_ena), 64'd0);
    exp_q.push_back(64'hFFFFFFFE_00000001);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    check("t2_multu", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
    step();
    exp_q.push_back(64'h00000000_00000001);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    check("t2_mult", {hi_out, lo_out}, 64'h00000000_00000001);
    step();
    req_valid = 1'b1;
    req_op = 3'b011;
    op_a = 32'h00001234;
    step();
    check("t3_mthi", 64'(hi_out), 64'h1234);
    check("t3_busy_mthi", 64'(busy), 64'd0);
    req_op = 3'b100;
    op_a = 32'h0000ABCD;
    step();
    check("t3_mtlo", {hi_out, lo_out}, 64'h00001234_0000ABCD);
    check("t3_busy_mtlo", 64'(busy), 64'd0);
    req_op = 3'b000;
    op_a = 32'h0000FFFF;
    step();
    check("t3_nop", {hi_out, lo_out}, 64'h00001234_0000ABCD);
    req_valid = 1'b0;
    exp_q.push_back(64'h00000000_00000015);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF8);
    req_valid = 1'b1;
    req_op = 3'b001;
    op_a = 32'd3;
    op_b = 32'd7;
    step();
    op_a = 32'hFFFFFFFE;
    op_b = 32'd4;
    for (int i = 0; i < 4; i++) begin
      check("t4_ready_low", 64'(req_ready), 64'd0);
      step();
    end
    check("t4_done_cycle_ready", {62'd0, req_ready, done}, 64'd3);
    check("t4_first", {hi_out, lo_out}, 64'h15);
    step();
    req_valid = 1'b0;
    check("t4_second_accepted", {62'd0, busy, mul_sign}, 64'd3);
    repeat (3) step();
    check("t4_before_e9", {hi_out, lo_out}, 64'h15);
    step();
    check("t4_at_e9", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF8);
    step();
    req_valid = 1'b1;
    req_op = 3'b011;
    op_a = 32'h11111111;
    step();
    req_op = 3'b100;
    op_a = 32'h22222222;
    step();
    req_valid = 1'b0;
    done_before = n_done;
    issue(3'b001, 32'd5, 32'd6);
    step();
    flush_sig = 1'b1;
    step();
    flush_sig = 1'b0;
    check("t5_idle", {62'd0, busy, req_ready}, 64'd1);
    check("t5_ena_off", 64'(mul_ena), 64'd0);
    repeat (6) step();
    check("t5_hilo_kept", {hi_out, lo_out}, 64'h11111111_22222222);
    check("t5_no_done", 64'(n_done), 64'(done_before));
    req_valid = 1'b1;
    req_op = 3'b011;
    op_a = 32'hDEADBEEF;
    flush_sig = 1'b1;
    step();
    flush_sig = 1'b0;
    req_valid = 1'b0;
    check("t5_flush_discard", 64'(hi_out), 64'h11111111);
    issue(3'b001, 32'd9, 32'd9);
    step();
    #2;
    rst_n_sig = 1'b0;
    #1;
    check("t6_async_hilo", {hi_out, lo_out}, 64'd0);
    check("t6_async_ctrl", {62'd0, busy, mul_ena}, 64'd0);
    step();
    rst_n_sig = 1'b1;
    step();
    exp_q.push_back(64'd0);
    issue(3'b010, 32'd0, 32'd7);
    wait_done();
    check("t6_multu_zero", {hi_out, lo_out}, 64'd0);
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
